fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single write port of one FIFO among NUM_REQ producers using round-robin arbitration with bounded bursts.
- Each producer has a valid/ack word handshake. The block drives the FIFO's wr_en/wdata and obeys its full flag, so the FIFO never sees a write while full (no wr_error).
- Sits in the write-clock domain, directly in front of the FIFO write port.

Parameters:
- NUM_REQ, 4, number of producers (>=2).
- WIDTH, 8, data width; matches the FIFO WIDTH.
- MAX_BURST, 4, maximum words accepted per grant (>=1).
- IDX_W, $clog2(NUM_REQ), owner index width.
- CNT_W, $clog2(MAX_BURST)+1, burst counter width.

Ports:
- clk  in  1  single clock, rising edge; driven by the FIFO write clock.
- reset  in  1  asynchronous, active-low reset.
- arb_en  in  1  1 = new grants allowed; 0 = the current burst finishes, then no new grants.
- req  in  NUM_REQ  per-producer word valid.
- req_data  in  NUM_REQ*WIDTH  producer i data on bits [i*WIDTH +: WIDTH].
- req_last  in  NUM_REQ  producer i marks its final word of the packet.
- ack  out  NUM_REQ  one-hot word accepted this cycle (combinational).
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write strobe (combinational, equals |ack).
- fifo_wdata  out  WIDTH  FIFO write data.
- owner  out  IDX_W  index of the current grant holder (registered).
- owner_valid  out  1  a grant is active (state == BURST).

Behaviour:
- Reset (reset=0, async, effective immediately, including mid-burst):
  - state=IDLE, owner=0, last=NUM_REQ-1, burst_cnt=0, owner_valid=0.
  - ack=0, fifo_wr_en=0, fifo_wdata=0.
  - On release, the first search starts at index 0.
- States: IDLE, BURST.
- Round-robin pick: first set bit of req, searching last+1, last+2, … modulo NUM_REQ. The previous owner has the lowest priority.
- IDLE:
  - If arb_en && |req: owner<=pick, last<=pick, burst_cnt<=0, go to BURST.
  - Else stay in IDLE.
  - One cycle of arbitration latency; no acks are issued in IDLE.
- BURST:
  - accept = req[owner] && !fifo_full.
  - ack[owner]=accept, fifo_wr_en=accept.
  - fifo_wdata = req_data[owner] when accept, else 0.
  - On accept: burst_cnt<=burst_cnt+1.
- Release from BURST when any of the following holds:
  - (a) accept && req_last[owner];
  - (b) accept && burst_cnt==MAX_BURST-1;
  - (c) !req[owner] (producer withdrew; no ack that cycle).
- On release:
  - If arb_en and some req is set, excluding the outgoing owner for case (c) but including it at lowest priority for (a)/(b): re-grant in the same edge (owner<=pick, last<=pick, burst_cnt<=0, stay in BURST). No bubble cycle.
  - Otherwise go to IDLE, owner_valid<=0.
- fifo_full during BURST: no ack, grant held, burst_cnt frozen. Full never causes a release.
- arb_en=0 mid-burst: the burst continues to normal release, then the block goes to IDLE.
- fifo_full and !req[owner] in the same cycle: case (c) applies.
- Simultaneous requests with last=1, req=4'b1011: grant order 3, 0, 1, 3, …
- Counter rule: burst_cnt never exceeds MAX_BURST-1; it clears on every grant.
- Invariants:
  - ack is one-hot or zero.
  - fifo_wr_en implies !fifo_full.
  - owner is stable for the whole burst.

Decomposition:
- Package fifo_arb_pkg:
  - typedef enum logic {IDLE, BURST} arb_state_t;
  - default localparams for NUM_REQ, WIDTH, MAX_BURST.
- Sub-module rr_pick:
  - Inputs: req vector, last index, exclude-enable, exclude index.
  - Outputs: pick index, pick_valid.
  - Purely combinational; instantiated once.

Test Plan:
- Reset mid-burst: after 2 words from producer 1, drop reset -> ack=0, fifo_wr_en=0, owner_valid=0 in the same cycle. After release with req=4'b0010: owner=1 one cycle later.
- Burst cap: MAX_BURST=4, req=4'b0101 held, req_last=0 -> fifo_wr_en continuous; 4 words from producer 0, then 4 from producer 2, then producer 0 again; no idle cycle between grants.
- Full stall: producer 3 granted, fifo_full=1 for 3 cycles after word 2 -> ack=0 and owner=3 during the stall; words 3-4 then complete, with total written equal to 4.
- Early last: req=4'b0011, producer 0 asserts req_last on word 2 (data 8'hA1, 8'hA2) -> FIFO receives A1, A2, then producer 1's data from the next cycle.
- Withdrawal: owner 2 drops req with no last -> release with no ack that cycle; with req=4'b0100 only, go to IDLE, owner_valid=0.
- arb_en=0 during a burst of producer 1 -> the burst completes (4 words), then IDLE with req=4'b1111 pending. Set arb_en=1 -> owner=2 on the next edge.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// rtl/fifo_wr_arbiter_pkg.sv - shared types and default parameters for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer handshake and FIFO write-port bundle
//   req/req_data/req_last : producer word valid, data, end-of-packet
//   ack                   : one-hot word accepted
//   fifo_full             : FIFO full flag
//   fifo_wr_en/fifo_wdata : FIFO write strobe and data
//   master modport = arbiter side, slave modport = producers + FIFO side
interface fifo_wr_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ-1:0]       ack;
    logic                     fifo_full;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_wdata;

    modport master (
        input  req, req_data, req_last, fifo_full,
        output ack, fifo_wr_en, fifo_wdata
    );

    modport slave (
        output req, req_data, req_last, fifo_full,
        input  ack, fifo_wr_en, fifo_wdata
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rtl/fifo_wr_arbiter_rr_pick.sv - combinational round-robin picker
//   req       : request vector
//   last      : previous grant index; search starts at last+1
//   excl_en   : when set, excl_idx is never picked
//   excl_idx  : index to skip
//   pick      : chosen index (0 when none)
//   pick_valid: some eligible request exists
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               excl_en,
    input  logic [IDX_W-1:0]   excl_idx,
    output logic [IDX_W-1:0]   pick,
    output logic               pick_valid
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest eligible
    // request after 'last' overwrites any farther one; offset NUM_REQ
    // lands on 'last' itself, giving the previous owner lowest priority.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        idx        = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (req[idx] && !(excl_en && (IDX_W'(idx) == excl_idx))) begin
                pick       = IDX_W'(idx);
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded sharing of one FIFO write port
//   clk         : FIFO write clock
//   reset       : asynchronous active-low reset
//   arb_en      : allow new grants
//   bus         : producer handshakes + FIFO write port (master modport)
//   owner       : current grant holder (registered)
//   owner_valid : grant active
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDX_W     = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                arb_en,
    fifo_wr_arbiter_if.master   bus,
    output logic [IDX_W-1:0]    owner,
    output logic                owner_valid
);

    arb_state_t       state;
    logic [IDX_W-1:0] last_q;
    logic [CNT_W-1:0] burst_cnt;

    logic             own_req;
    logic             accept;
    logic             cap_hit;
    logic             release_now;
    logic             excl_en;
    logic             grant_now;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;

    assign own_req = bus.req[owner];
    assign accept  = (state == BURST) && own_req && !bus.fifo_full;
    assign cap_hit = (burst_cnt == CNT_W'(MAX_BURST - 1));

    // fifo_full only stalls; it never ends a burst.
    assign release_now = (state == BURST) &&
                         (!own_req || (accept && (bus.req_last[owner] || cap_hit)));

    // A withdrawn owner is skipped on re-grant; a normally finishing owner
    // stays eligible, at lowest priority because last_q == owner.
    assign excl_en   = (state == BURST) && !own_req;
    assign grant_now = arb_en && pick_valid && ((state == IDLE) || release_now);

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (bus.req),
        .last       (last_q),
        .excl_en    (excl_en),
        .excl_idx   (owner),
        .pick       (pick),
        .pick_valid (pick_valid)
    );

    always_comb begin
        bus.ack        = '0;
        bus.ack[owner] = accept;
    end

    assign bus.fifo_wr_en = accept;
    assign bus.fifo_wdata = accept ? bus.req_data[owner*WIDTH +: WIDTH] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= '0;
            last_q      <= IDX_W'(NUM_REQ - 1);
            burst_cnt   <= '0;
            owner_valid <= 1'b0;
        end else if (grant_now) begin
            state       <= BURST;
            owner       <= pick;
            last_q      <= pick;
            burst_cnt   <= '0;
            owner_valid <= 1'b1;
        end else if (release_now) begin
            state       <= IDLE;
            burst_cnt   <= '0;
            owner_valid <= 1'b0;
        end else if (accept) begin
            burst_cnt   <= burst_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       arb_en = 1'b0;
    logic [1:0] owner;
    logic       owner_valid;

    fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .WIDTH     (W),
        .MAX_BURST (MB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .arb_en      (arb_en),
        .bus         (bus),
        .owner       (owner),
        .owner_valid (owner_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int words = 0;
    int grants[$];

    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = N - 1;
    int m_cnt   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] r, input int from, input int excl);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (from + k) % N;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    task automatic grant(input int p);
        m_owner = p;
        m_last  = p;
        m_cnt   = 0;
        m_busy  = 1'b1;
        grants.push_back(p);
    endtask

    // Called just after a falling edge with inputs already driven: checks
    // outputs against the model, advances the model, moves to next falling edge.
    task automatic cycle();
        bit              acc;
        int              p;
        logic [N-1:0]    exp_ack;
        logic [W-1:0]    exp_d;
        #1;
        if (!reset) begin
            m_busy  = 1'b0;
            m_owner = 0;
            m_last  = N - 1;
            m_cnt   = 0;
        end
        acc     = m_busy && bus.req[m_owner] && !bus.fifo_full;
        exp_ack = acc ? (N'(1) << m_owner) : '0;
        exp_d   = acc ? bus.req_data[m_owner*W +: W] : '0;
        chk("owner_valid", 32'(owner_valid), 32'(m_busy));
        chk("owner",       32'(owner),       32'(m_owner));
        chk("ack",         32'(bus.ack),     32'(exp_ack));
        chk("wr_en",       32'(bus.fifo_wr_en), 32'(acc));
        chk("wdata",       32'(bus.fifo_wdata), 32'(exp_d));
        if (acc) words++;
        if (reset) begin
            if (!m_busy) begin
                if (arb_en && bus.req != '0) grant(rr(bus.req, m_last, -1));
            end else begin
                if (acc) m_cnt++;
                if (!bus.req[m_owner] ||
                    (acc && (bus.req_last[m_owner] || m_cnt == MB))) begin
                    p = rr(bus.req, m_last, bus.req[m_owner] ? -1 : m_owner);
                    if (arb_en && p >= 0) grant(p);
                    else m_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
        bus.req       = r;
        bus.req_last  = l;
        bus.fifo_full = f;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        @(negedge clk);

        // reset state
        cycle();
        cycle();
        reset = 1'b1;

        // simultaneous requests: from last=3, order 0,1,3,0
        arb_en = 1'b1;
        bus.req_data = 32'h44332211;
        grants.delete();
        drive(4'b1011, 4'b1111, 1'b0);
        repeat (4) cycle();
        chk("order_len", 32'(grants.size()), 32'd4);
        chk("order_0", 32'(grants[0]), 32'd0);
        chk("order_1", 32'(grants[1]), 32'd1);
        chk("order_2", 32'(grants[2]), 32'd3);
        chk("order_3", 32'(grants[3]), 32'd0);

        // reset mid-burst after 2 words from producer 1
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        drive(4'b0010, 4'b0000, 1'b0);
        cycle();
        words = 0;
        bus.req_data = 32'h00005500;
        cycle();
        bus.req_data = 32'h00006600;
        cycle();
        chk("pre_reset_words", 32'(words), 32'd2);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        #1;
        chk("rst_regrant_owner", 32'(owner), 32'd1);
        chk("rst_regrant_valid", 32'(owner_valid), 32'd1);

        // burst cap with two producers: no bubble between grants
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        drive(4'b0101, 4'b0000, 1'b0);
        grants.delete();
        cycle();
        words = 0;
        for (int i = 0; i < 12; i++) begin
            bus.req_data = $urandom;
            cycle();
        end
        chk("cap_words", 32'(words), 32'd12);
        chk("cap_grants", 32'(grants.size()), 32'd4);
        chk("cap_grant1", 32'(grants[1]), 32'd0);
        chk("cap_grant2", 32'(grants[2]), 32'd2);

        // full stall during producer 3 burst
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        drive(4'b1000, 4'b0000, 1'b0);
        cycle();
        words = 0;
        repeat (2) cycle();
        bus.fifo_full = 1'b1;
        repeat (3) cycle();
        bus.fifo_full = 1'b0;
        repeat (2) cycle();
        chk("stall_words", 32'(words), 32'd4);

        // early last from producer 0, producer 1 follows without a bubble
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        drive(4'b0011, 4'b0000, 1'b0);
        bus.req_data = 32'h0000B0A1;
        cycle();
        cycle();
        bus.req_data = 32'h0000B0A2;
        bus.req_last = 4'b0001;
        cycle();
        drive(4'b0010, 4'b0000, 1'b0);
        #1;
        chk("early_last_next", 32'(bus.fifo_wdata), 32'h000000B0);
        cycle();

        // withdrawal by owner 2 -> idle
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        drive(4'b0100, 4'b0000, 1'b0);
        cycle();
        cycle();
        drive(4'b0000, 4'b0000, 1'b0);
        cycle();
        cycle();

        // arb_en low mid-burst of producer 1
        drive(4'b0010, 4'b0000, 1'b0);
        cycle();
        arb_en = 1'b0;
        drive(4'b1111, 4'b0000, 1'b0);
        repeat (6) cycle();
        arb_en = 1'b1;
        cycle();
        #1;
        chk("reenable_owner", 32'(owner), 32'd2);
        chk("reenable_valid", 32'(owner_valid), 32'd1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bus.req       = N'($urandom);
            bus.req_last  = N'($urandom) & N'($urandom);
            bus.req_data  = $urandom;
            bus.fifo_full = ($urandom_range(0, 4) == 0);
            arb_en        = ($urandom_range(0, 7) != 0);
            reset         = ($urandom_range(0, 199) != 0);
            cycle();
        end
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
